// File: rtl/matmul_mem_if.sv
// matmul_mem_if: engine A/B/C memory ports, host req/ack port and status for matmul_mem_responder.
interface matmul_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              mem_read_en_A;
    logic [ADDR_W-1:0] mem_addr_A;
    logic [DATA_W-1:0] mem_data_A;
    logic              mem_read_en_B;
    logic [ADDR_W-1:0] mem_addr_B;
    logic [DATA_W-1:0] mem_data_B;
    logic              mem_write_en_C;
    logic [ADDR_W-1:0] mem_addr_C;
    logic [DATA_W-1:0] mem_data_C;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic [3:0]        err_flags;
    logic [7:0]        wr_cnt_C;
    logic              stats_clr;

    modport master (
        output mem_read_en_A, mem_addr_A, mem_read_en_B, mem_addr_B,
        output mem_write_en_C, mem_addr_C, mem_data_C,
        output host_req, host_we, host_addr, host_wdata, stats_clr,
        input  mem_data_A, mem_data_B, host_ack, host_rdata, err_flags, wr_cnt_C
    );

    modport slave (
        input  mem_read_en_A, mem_addr_A, mem_read_en_B, mem_addr_B,
        input  mem_write_en_C, mem_addr_C, mem_data_C,
        input  host_req, host_we, host_addr, host_wdata, stats_clr,
        output mem_data_A, mem_data_B, host_ack, host_rdata, err_flags, wr_cnt_C
    );
endinterface

// File: rtl/matmul_mem_responder.sv
// matmul_mem_responder: A/B/C word memories serving the matmul engine at 1-cycle latency,
// with a lower-priority host req/ack port, sticky error flags and a C write counter.
module matmul_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16
) (
    input logic         clk,
    input logic         rstn,
    matmul_mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {H_IDLE, H_ACK, H_DRAIN} h_state_t;

    h_state_t          state;
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] mem_c [DEPTH];
    logic [IDX_W-1:0]  idx_a, idx_b, idx_c, idx_h;
    logic [1:0]        h_reg;
    logic              ok_a, ok_b, ok_c, ok_h, wr_c, busy, h_go;
    logic [DATA_W-1:0] h_word;

    // Legal iff everything above the word index equals the region number in the top two bits.
    function automatic logic legal(input logic [ADDR_W-1:0] a, input logic [1:0] r);
        return (a >> IDX_W) == ({r, {(ADDR_W-2){1'b0}}} >> IDX_W);
    endfunction

    assign idx_a  = bus.mem_addr_A[IDX_W-1:0];
    assign idx_b  = bus.mem_addr_B[IDX_W-1:0];
    assign idx_c  = bus.mem_addr_C[IDX_W-1:0];
    assign idx_h  = bus.host_addr[IDX_W-1:0];
    assign h_reg  = bus.host_addr[ADDR_W-1 -: 2];
    assign ok_a   = legal(bus.mem_addr_A, 2'd0);
    assign ok_b   = legal(bus.mem_addr_B, 2'd1);
    assign ok_c   = legal(bus.mem_addr_C, 2'd2);
    assign ok_h   = h_reg != 2'd3 && legal(bus.host_addr, h_reg);
    assign wr_c   = bus.mem_write_en_C && ok_c;
    assign busy   = bus.mem_read_en_A || bus.mem_read_en_B || bus.mem_write_en_C;
    // Gated by rstn so a request held through reset cannot commit a write.
    assign h_go   = rstn && state == H_IDLE && bus.host_req && !busy;
    assign h_word = h_reg == 2'd0 ? mem_a[idx_h] : h_reg == 2'd1 ? mem_b[idx_h] : mem_c[idx_h];

    always_ff @(posedge clk) begin
        if (wr_c) mem_c[idx_c] <= bus.mem_data_C;
        if (h_go && bus.host_we && ok_h) begin
            if (h_reg == 2'd0) mem_a[idx_h] <= bus.host_wdata;
            else if (h_reg == 2'd1) mem_b[idx_h] <= bus.host_wdata;
            else mem_c[idx_h] <= bus.host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= H_IDLE;
            bus.mem_data_A <= '0;
            bus.mem_data_B <= '0;
            bus.host_ack   <= 1'b0;
            bus.host_rdata <= '0;
            bus.err_flags  <= '0;
            bus.wr_cnt_C   <= '0;
        end else begin
            if (bus.mem_read_en_A) bus.mem_data_A <= ok_a ? mem_a[idx_a] : '0;
            if (bus.mem_read_en_B) bus.mem_data_B <= ok_b ? mem_b[idx_b] : '0;
            if (h_go && !bus.host_we) bus.host_rdata <= ok_h ? h_word : '0;
            bus.host_ack <= h_go;
            state <= h_go ? H_ACK :
                     state == H_ACK ? H_DRAIN :
                     (state == H_DRAIN && !bus.host_req) ? H_IDLE : state;
            bus.err_flags <= bus.stats_clr ? 4'd0 : bus.err_flags |
                             {h_go && !ok_h, bus.mem_write_en_C && !ok_c,
                              bus.mem_read_en_B && !ok_b, bus.mem_read_en_A && !ok_a};
            bus.wr_cnt_C <= bus.stats_clr ? 8'd0 :
                            (wr_c && bus.wr_cnt_C != 8'hFF) ? bus.wr_cnt_C + 8'd1 : bus.wr_cnt_C;
        end
    end
endmodule
